dkey_schedule: RTL

Iterative AES-128 key-expansion stage that sits directly upstream of the decryption round pipeline and feeds it round keys. It accepts a 128-bit cipher key and computes one round key per clock: ten expansion cycles produce all eleven round keys. The keys are held in an internal register file, and the decryption datapath reads them by round index, from 10 down to 0. This replaces the chain of ten combinational key-expansion instances with one shared expansion step.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_sbox.sv | 28 ++
 rtl/dkey_schedule.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the key schedule.
package aes_pkg;

   localparam int unsigned NR = 10;
   localparam int unsigned NK = 4;

   // Indexed directly by the round counter; entry 0 and 11..15 are unused padding.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         r[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         r[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         r[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared with the encryption datapath.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/dkey_schedule.sv
// Iterative AES-128 key expansion feeding the decryption rounds: one round key per clock.
// Define DKEY_SCHEDULE_EQINV_EN to read keys 1..NR-1 through InvMixColumns (equivalent inverse cipher).
module dkey_schedule
   import aes_pkg::*;
#(
   parameter int unsigned NR = aes_pkg::NR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   input  logic [127:0] key_in,
   output logic         key_ready,
   output logic         busy,
   output logic         done,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);

   state_e       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] w_q, w_d;
   logic [127:0] keys_q [NR+1];
   logic [127:0] keys_d [NR+1];
   logic         key_ready_q, key_ready_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [31:0]  rot_w, sub_w, t_w;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic [127:0] next_w;
   logic [127:0] raw_key;

   assign rot_w = {w_q[23:0], w_q[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (rot_w[8*b +: 8]),
         .out_byte (sub_w[8*b +: 8])
      );
   end

   always_comb begin
      t_w    = sub_w ^ {RCON[rnd_q], 24'h0};
      nw0    = w_q[127:96] ^ t_w;
      nw1    = w_q[95:64]  ^ nw0;
      nw2    = w_q[63:32]  ^ nw1;
      nw3    = w_q[31:0]   ^ nw2;
      next_w = {nw0, nw1, nw2, nw3};
   end

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      w_d     = w_q;
      keys_d  = keys_q;
      case (state_q)
         IDLE, DONE: begin
            if (key_valid && key_ready_q) begin
               state_d   = EXPAND;
               rnd_d     = 4'd1;
               w_d       = key_in;
               keys_d[0] = key_in;
            end
         end
         EXPAND: begin
            for (int unsigned i = 1; i <= NR; i++) begin
               if (rnd_q == i[3:0]) keys_d[i] = next_w;
            end
            w_d   = next_w;
            rnd_d = rnd_q + 4'd1;
            if (32'(rnd_q) == NR) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      key_ready_d = (state_d != EXPAND);
      busy_d      = (state_d == EXPAND);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rnd_q       <= '0;
         w_q         <= '0;
         key_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int unsigned i = 0; i <= NR; i++) keys_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         w_q         <= w_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         keys_q      <= keys_d;
      end
   end

   assign key_ready = key_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Indices past NR match no entry and fall through to zero.
   always_comb begin
      raw_key = '0;
      for (int unsigned i = 0; i <= NR; i++) begin
         if (rd_idx == i[3:0]) raw_key = keys_q[i];
      end
   end

`ifdef DKEY_SCHEDULE_EQINV_EN
   always_comb begin
      if (rd_idx != 4'd0 && 32'(rd_idx) < NR) rd_key = inv_mix_columns(raw_key);
      else                                    rd_key = raw_key;
   end
`else
   assign rd_key = raw_key;
`endif

endmodule
